// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: synchronises and de-glitches the raw
// PS/2 clock/data lines and deserialises 11-bit frames into scan-code bytes.
//
// Ports:
//   clk        system clock (50 MHz)
//   rst        asynchronous, active-low reset
//   ps2Clk     raw PS/2 clock line (asynchronous)
//   ps2Data    raw PS/2 data line (asynchronous)
//   code       last correctly received byte, held until the next good frame
//   valid      one-cycle pulse, code updated in the same cycle
//   parity_err one-cycle pulse, odd-parity check failed, frame discarded
//   frame_err  one-cycle pulse, bad start/stop bit or mid-frame timeout
//   busy       high while a frame is in progress
module ps2_rx_frame #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT     = 10000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2Clk,
    input  logic       ps2Data,
    output logic [7:0] code,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic [FILTER_LEN-1:0]  clk_hist;
    logic                   clk_filt;
    logic                   clk_filt_q;
    logic                   fall;
    logic                   bit_in;

    logic [7:0]    shreg, shreg_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic          par_bit, par_bit_n;
    logic [TW-1:0] tcnt;
    logic          timeout;

    logic [7:0] code_n;
    logic       valid_n;
    logic       parity_err_n;
    logic       frame_err_n;

    // Synchronisers and clock glitch filter; all idle-high after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync   <= '1;
            data_sync  <= '1;
            clk_hist   <= '1;
            clk_filt   <= 1'b1;
            clk_filt_q <= 1'b1;
        end else begin
            clk_sync   <= {clk_sync[SYNC_STAGES-2:0], ps2Clk};
            data_sync  <= {data_sync[SYNC_STAGES-2:0], ps2Data};
            clk_hist   <= {clk_hist[FILTER_LEN-2:0],
                           clk_sync[SYNC_STAGES-1]};
            clk_filt_q <= clk_filt;
            if (&clk_hist) begin
                clk_filt <= 1'b1;
            end else if (~|clk_hist) begin
                clk_filt <= 1'b0;
            end
        end
    end

    assign fall    = clk_filt_q & ~clk_filt;
    assign bit_in  = data_sync[SYNC_STAGES-1];
    assign timeout = (tcnt == TW'(TIMEOUT));
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            par_bit    <= 1'b0;
            tcnt       <= '0;
            code       <= 8'h00;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            bit_cnt    <= bit_cnt_n;
            par_bit    <= par_bit_n;
            code       <= code_n;
            valid      <= valid_n;
            parity_err <= parity_err_n;
            frame_err  <= frame_err_n;
            // Saturating: a stuck line must not wrap back into a frame.
            if (state == IDLE || fall) begin
                tcnt <= '0;
            end else if (!timeout) begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_n      = state;
        shreg_n      = shreg;
        bit_cnt_n    = bit_cnt;
        par_bit_n    = par_bit;
        code_n       = code;
        valid_n      = 1'b0;
        parity_err_n = 1'b0;
        frame_err_n  = 1'b0;

        if (state != IDLE && timeout) begin
            frame_err_n = 1'b1;
            state_n     = IDLE;
        end else if (fall) begin
            unique case (state)
                IDLE: begin
                    if (!bit_in) begin
                        state_n   = DATA;
                        bit_cnt_n = '0;
                    end else begin
                        frame_err_n = 1'b1;
                    end
                end
                DATA: begin
                    shreg_n   = {bit_in, shreg[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_n = PARITY;
                    end
                end
                PARITY: begin
                    par_bit_n = bit_in;
                    state_n   = STOP;
                end
                STOP: begin
                    state_n = IDLE;
                    if (!bit_in) begin
                        frame_err_n = 1'b1;
                    end else if (^{shreg, par_bit}) begin
                        code_n  = shreg;
                        valid_n = 1'b1;
                    end else begin
                        parity_err_n = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Directed self-checking bench for ps2_rx_frame.
// PS/2 lines are driven on clk negedges with a short bit period.
module tb_ps2_rx_frame;

    localparam int TO    = 200;
    localparam int HALF  = 20;
    // raw edge -> fall pulse = 2 sync + 4 filter + 1 filt reg;
    // +1 counter clear, +TO count, +1 output register
    localparam int TO_LAT = TO + 9;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2Clk = 1'b1;
    logic       ps2Data = 1'b1;
    logic [7:0] code;
    logic       valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t_fall  = 0;
    int v_cnt, p_cnt, f_cnt, multi;
    int first_v, first_f;
    logic [7:0] codes[$];
    bit glitch_en = 1'b0;

    ps2_rx_frame #(
        .SYNC_STAGES(2),
        .FILTER_LEN(4),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ps2Clk(ps2Clk),
        .ps2Data(ps2Data),
        .code(code),
        .valid(valid),
        .parity_err(parity_err),
        .frame_err(frame_err),
        .busy(busy)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (valid) begin
            v_cnt++;
            codes.push_back(code);
            if (first_v < 0) first_v = cyc;
        end
        if (parity_err) p_cnt++;
        if (frame_err) begin
            f_cnt++;
            if (first_f < 0) first_f = cyc;
        end
        if (int'(valid) + int'(parity_err) + int'(frame_err) > 1)
            multi++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        v_cnt = 0;
        p_cnt = 0;
        f_cnt = 0;
        multi = 0;
        first_v = -1;
        first_f = -1;
        codes.delete();
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        ps2Data = b;
        if (glitch_en) begin
            repeat (8) @(negedge clk);
            ps2Clk = 1'b0;
            repeat (2) @(negedge clk);
            ps2Clk = 1'b1;
            repeat (HALF - 11) @(negedge clk);
        end else begin
            repeat (HALF - 1) @(negedge clk);
        end
        ps2Clk = 1'b0;
        t_fall = cyc;
        repeat (HALF) @(negedge clk);
        ps2Clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par,
                              input logic stop);
        logic p;
        p = ~^d ^ bad_par;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(stop);
    endtask

    task automatic settle();
        @(negedge clk);
        ps2Data = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        clear_mon();
        repeat (3) @(negedge clk);
        check("reset_code", code, 8'h00);
        check("reset_outs", {valid, parity_err, frame_err, busy}, 4'b0000);
        rst = 1'b1;
        repeat (10) @(negedge clk);

        // Valid frame 0x1D plus latency from raw stop-bit edge
        clear_mon();
        send_frame(8'h1D, 1'b0, 1'b1);
        check("1d_latency_ok", 32'((first_v - t_fall) <= 9 &&
                                   (first_v - t_fall) > 0), 1);
        settle();
        check("1d_valid_cnt", v_cnt, 1);
        check("1d_code", code, 8'h1D);
        check("1d_busy", busy, 1'b0);
        check("1d_errs", p_cnt + f_cnt, 0);

        // Back-to-back break sequence
        clear_mon();
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h1B, 1'b0, 1'b1);
        settle();
        check("b2b_valid_cnt", v_cnt, 2);
        check("b2b_code0", codes.size() > 0 ? codes[0] : 8'hxx, 8'hF0);
        check("b2b_code1", codes.size() > 1 ? codes[1] : 8'hxx, 8'h1B);
        check("b2b_errs", p_cnt + f_cnt, 0);

        // Bad parity
        clear_mon();
        send_frame(8'h44, 1'b1, 1'b1);
        settle();
        check("par_perr_cnt", p_cnt, 1);
        check("par_valid_cnt", v_cnt, 0);
        check("par_ferr_cnt", f_cnt, 0);
        check("par_code", code, 8'h1B);

        // Bad stop, then a good copy
        clear_mon();
        send_frame(8'h4B, 1'b0, 1'b0);
        settle();
        check("stop_ferr_cnt", f_cnt, 1);
        check("stop_other", v_cnt + p_cnt, 0);
        check("stop_code", code, 8'h1B);
        clear_mon();
        send_frame(8'h4B, 1'b0, 1'b1);
        settle();
        check("stop_good_code", code, 8'h4B);
        check("stop_good_valid", v_cnt, 1);

        // Bad start bit while idle
        clear_mon();
        send_bit(1'b1);
        settle();
        check("start_ferr_cnt", f_cnt, 1);
        check("start_busy", busy, 1'b0);

        // Timeout: start + 5 data bits then the clock stays high
        clear_mon();
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        check("to_busy_mid", busy, 1'b1);
        for (int i = 0; i < TO + 50 && first_f < 0; i++)
            @(negedge clk);
        check("to_seen", 32'(first_f >= 0), 1);
        check("to_latency", first_f - t_fall, TO_LAT);
        check("to_busy_after", busy, 1'b0);
        check("to_code", code, 8'h4B);
        clear_mon();
        send_frame(8'h44, 1'b0, 1'b1);
        settle();
        check("to_next_code", code, 8'h44);
        check("to_next_valid", v_cnt, 1);

        // Glitches on ps2Clk during each bit's high phase
        clear_mon();
        glitch_en = 1'b1;
        send_frame(8'hA5, 1'b0, 1'b1);
        glitch_en = 1'b0;
        settle();
        check("gl_code", code, 8'hA5);
        check("gl_valid_cnt", v_cnt, 1);
        check("gl_errs", p_cnt + f_cnt, 0);

        // Asynchronous reset mid-frame
        clear_mon();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        @(negedge clk);
        #3 rst = 1'b0;
        #1;
        check("rst_code", code, 8'h00);
        check("rst_outs", {valid, parity_err, frame_err, busy}, 4'b0000);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        clear_mon();
        send_frame(8'h5A, 1'b0, 1'b1);
        settle();
        check("rst_next_code", code, 8'h5A);
        check("rst_next_valid", v_cnt, 1);
        check("rst_next_errs", p_cnt + f_cnt, 0);

        check("onehot_pulses", multi, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

endmodule
